// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and a variable-latency data memory (slave).
// Requests are levels held until dm_rdy; read data is qualified by dm_rdy.
interface mem_stage_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_re;
  logic              dm_we;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_rdy;

  modport master (
    output dm_addr,
    output dm_wdata,
    output dm_re,
    output dm_we,
    input  dm_rdata,
    input  dm_rdy
  );

  modport slave (
    input  dm_addr,
    input  dm_wdata,
    input  dm_re,
    input  dm_we,
    output dm_rdata,
    output dm_rdy
  );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: forwards ALU results, or runs one load/store on the data-memory bus,
// stalling EX until the memory answers or the access times out.
module mem_stage #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] dst_i,
  input  logic [DATA_W-1:0] sdata_i,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  output logic              stall_o,
  mem_stage_if.master       dm,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_valid_o,
  output logic              mem_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t            state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [DATA_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic              re_q,       re_d;
  logic              we_q,       we_d;
  logic [DATA_W-1:0] wb_data_q,  wb_data_d;
  logic              wb_valid_q, wb_valid_d;
  logic              err_q,      err_d;
  logic              last_s;

  assign last_s = (cnt_q == CNT_LAST);

  // Next-state, request handling and EX stall decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    re_d       = re_q;
    we_d       = we_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    err_d      = err_q;
    stall_o    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          if (mem_re_i && mem_we_i) begin
            err_d = 1'b1;
          end else if (mem_re_i || mem_we_i) begin
            stall_o = 1'b1;
            addr_d  = dst_i;
            wdata_d = sdata_i;
            re_d    = mem_re_i;
            we_d    = mem_we_i;
            cnt_d   = CNT_ZERO;
            state_d = ST_ACCESS;
          end else begin
            wb_data_d  = dst_i;
            wb_valid_d = 1'b1;
          end
        end else begin
          wb_valid_d = 1'b0;
        end
      end
      ST_ACCESS: begin
        cnt_d   = cnt_q + CNT_ONE;
        stall_o = ~dm.dm_rdy & ~last_s;
        if (dm.dm_rdy) begin
          if (re_q) begin
            wb_data_d  = dm.dm_rdata;
            wb_valid_d = 1'b1;
          end else begin
            wb_valid_d = 1'b0;
          end
          re_d    = 1'b0;
          we_d    = 1'b0;
          state_d = ST_IDLE;
        end else if (last_s) begin
          // Aborted loads still retire (with zero) so the destination register is defined.
          if (re_q) begin
            wb_data_d  = {DATA_W{1'b0}};
            wb_valid_d = 1'b1;
          end else begin
            wb_valid_d = 1'b0;
          end
          re_d    = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default: begin
        re_d    = 1'b0;
        we_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, bus and write-back registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      addr_q     <= {DATA_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      wb_data_q  <= {DATA_W{1'b0}};
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      re_q       <= re_d;
      we_q       <= we_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
      err_q      <= err_d;
    end
  end

  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;
  assign dm.dm_re    = re_q;
  assign dm.dm_we    = we_q;
  assign wb_data_o   = wb_data_q;
  assign wb_valid_o  = wb_valid_q;
  assign mem_err_o   = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change and outputs are checked just after each falling
// edge; the bench itself plays the data memory on the interface.
module tb_mem_stage;
  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [15:0] dst;
  logic [15:0] sdata;
  logic        mem_re;
  logic        mem_we;
  logic        stall;
  logic [15:0] wb_data;
  logic        wb_valid;
  logic        mem_err;
  int          n_cmp;
  int          n_bad;

  mem_stage_if #(.DATA_W(16)) dmif ();

  mem_stage #(.DATA_W(16), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid),
    .dst_i      (dst),
    .sdata_i    (sdata),
    .mem_re_i   (mem_re),
    .mem_we_i   (mem_we),
    .stall_o    (stall),
    .dm         (dmif.master),
    .wb_data_o  (wb_data),
    .wb_valid_o (wb_valid),
    .mem_err_o  (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    valid  = 1'b0;
    mem_re = 1'b0;
    mem_we = 1'b0;
    dst    = 16'h0000;
    sdata  = 16'h0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    dmif.dm_rdy   = 1'b0;
    dmif.dm_rdata = 16'h0000;
    step(); step(); settle();
    n_cmp++; if (dmif.dm_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_addr got %h exp 0000", dmif.dm_addr); end
    n_cmp++; if (dmif.dm_wdata !== 16'h0000) begin n_bad++; $display("FAIL reset_wdata got %h exp 0000", dmif.dm_wdata); end
    n_cmp++; if ({dmif.dm_re, dmif.dm_we} !== 2'b00) begin n_bad++; $display("FAIL reset_req got %b exp 00", {dmif.dm_re, dmif.dm_we}); end
    n_cmp++; if ({wb_valid, mem_err, stall} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b exp 000", {wb_valid, mem_err, stall}); end
    n_cmp++; if (wb_data !== 16'h0000) begin n_bad++; $display("FAIL reset_wbdata got %h exp 0000", wb_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    step();
    valid = 1'b1; dst = 16'h1234;
    settle();
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL t1_stall got %b exp 0", stall); end
    step();
    idle_inputs();
    settle();
    n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL t1_wb_valid got %b exp 1", wb_valid); end
    n_cmp++; if (wb_data !== 16'h1234) begin n_bad++; $display("FAIL t1_wb_data got %h exp 1234", wb_data); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL t1_stall_after got %b exp 0", stall); end
    step(); settle();
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL t1_pulse got %b exp 0", wb_valid); end
  endtask

  task automatic test_load_zero_wait();
    step();
    valid = 1'b1; mem_re = 1'b1; dst = 16'h0040;
    settle();
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL t2_stall_idle got %b exp 1", stall); end
    step();
    dmif.dm_rdy = 1'b1; dmif.dm_rdata = 16'hBEEF;
    settle();
    n_cmp++; if (dmif.dm_re !== 1'b1) begin n_bad++; $display("FAIL t2_dm_re got %b exp 1", dmif.dm_re); end
    n_cmp++; if (dmif.dm_addr !== 16'h0040) begin n_bad++; $display("FAIL t2_addr got %h exp 0040", dmif.dm_addr); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL t2_stall_rdy got %b exp 0", stall); end
    n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL t2_early_wb got %b exp 0", wb_valid); end
    step();
    idle_inputs();
    dmif.dm_rdy = 1'b0; dmif.dm_rdata = 16'h0000;
    settle();
    n_cmp++; if (wb_valid !== 1'b1) begin n_bad++; $display("FAIL t2_wb_valid got %b exp 1", wb_valid); end
    n_cmp++; if (wb_data !== 16'hBEEF) begin n_bad++; $display("FAIL t2_wb_data got %h exp beef", wb_data); end
    n_cmp++; if (dmif.dm_re !== 1'b0) begin n_bad++; $display("FAIL t2_re_drop got %b exp 0", dmif.dm_re); end
  endtask

  task automatic test_store_wait();
    step();
    valid = 1'b1; mem_we = 1'b1; dst = 16'h0100; sdata = 16'hA5A5;
    settle();
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL t3_stall_idle got %b exp 1", stall); end
    for (int k = 1; k <= 4; k++) begin
      step();
      dmif.dm_rdy = (k == 4);
      settle();
      n_cmp++; if (dmif.dm_we !== 1'b1 || dmif.dm_re !== 1'b0) begin n_bad++; $display("FAIL t3_req cyc %0d got we=%b re=%b exp we=1 re=0", k, dmif.dm_we, dmif.dm_re); end
      n_cmp++; if (dmif.dm_addr !== 16'h0100 || dmif.dm_wdata !== 16'hA5A5) begin n_bad++; $display("FAIL t3_bus cyc %0d got %h/%h exp 0100/a5a5", k, dmif.dm_addr, dmif.dm_wdata); end
      n_cmp++; if (stall !== (k != 4)) begin n_bad++; $display("FAIL t3_stall cyc %0d got %b exp %b", k, stall, (k != 4)); end
      n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL t3_wb cyc %0d got %b exp 0", k, wb_valid); end
    end
    step();
    idle_inputs();
    dmif.dm_rdy = 1'b0;
    settle();
    n_cmp++; if ({dmif.dm_we, wb_valid, mem_err} !== 3'b000) begin n_bad++; $display("FAIL t3_done got we/wbv/err=%b exp 000", {dmif.dm_we, wb_valid, mem_err}); end
  endtask

  task automatic test_timeout();
    step();
    valid = 1'b1; mem_re = 1'b1; dst = 16'h0200;
    dmif.dm_rdy = 1'b0;
    settle();
    n_cmp++; if (mem_err !== 1'b0) begin n_bad++; $display("FAIL t4_err_before got %b exp 0", mem_err); end
    for (int k = 1; k <= 15; k++) begin
      step(); settle();
      n_cmp++; if (dmif.dm_re !== 1'b1) begin n_bad++; $display("FAIL t4_re cyc %0d got %b exp 1", k, dmif.dm_re); end
      n_cmp++; if (stall !== (k != 15)) begin n_bad++; $display("FAIL t4_stall cyc %0d got %b exp %b", k, stall, (k != 15)); end
    end
    step();
    idle_inputs();
    settle();
    n_cmp++; if (dmif.dm_re !== 1'b0) begin n_bad++; $display("FAIL t4_re_drop got %b exp 0", dmif.dm_re); end
    n_cmp++; if (mem_err !== 1'b1) begin n_bad++; $display("FAIL t4_err got %b exp 1", mem_err); end
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 16'h0000) begin n_bad++; $display("FAIL t4_wb got %b/%h exp 1/0000", wb_valid, wb_data); end
    step(); step(); settle();
    n_cmp++; if (mem_err !== 1'b1 || wb_valid !== 1'b0) begin n_bad++; $display("FAIL t4_sticky got err=%b wbv=%b exp 1/0", mem_err, wb_valid); end
  endtask

  task automatic test_illegal();
    step();
    valid = 1'b1; mem_re = 1'b1; mem_we = 1'b1; dst = 16'h0300;
    settle();
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL t5_stall got %b exp 0", stall); end
    step();
    mem_re = 1'b0; mem_we = 1'b0; dst = 16'h5678;
    settle();
    n_cmp++; if ({dmif.dm_re, dmif.dm_we} !== 2'b00) begin n_bad++; $display("FAIL t5_req got %b exp 00", {dmif.dm_re, dmif.dm_we}); end
    n_cmp++; if (mem_err !== 1'b1 || wb_valid !== 1'b0) begin n_bad++; $display("FAIL t5_err got err=%b wbv=%b exp 1/0", mem_err, wb_valid); end
    step();
    idle_inputs();
    settle();
    n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 16'h5678) begin n_bad++; $display("FAIL t5_next got %b/%h exp 1/5678", wb_valid, wb_data); end
    n_cmp++; if (mem_err !== 1'b1) begin n_bad++; $display("FAIL t5_sticky got %b exp 1", mem_err); end
  endtask

  task automatic test_reset_mid_access();
    step();
    valid = 1'b1; mem_re = 1'b1; dst = 16'h0400;
    dmif.dm_rdy = 1'b0;
    step(); settle();
    n_cmp++; if (dmif.dm_re !== 1'b1 || stall !== 1'b1) begin n_bad++; $display("FAIL t6_access got re=%b stall=%b exp 1/1", dmif.dm_re, stall); end
    step(); settle();
    rst_n = 1'b0;
    idle_inputs();
    settle();
    n_cmp++; if ({dmif.dm_re, stall, wb_valid, mem_err} !== 4'b0000) begin n_bad++; $display("FAIL t6_async got re/stall/wbv/err=%b exp 0000", {dmif.dm_re, stall, wb_valid, mem_err}); end
    n_cmp++; if (dmif.dm_addr !== 16'h0000) begin n_bad++; $display("FAIL t6_addr got %h exp 0000", dmif.dm_addr); end
    step();
    rst_n = 1'b1;
    step();
    dmif.dm_rdy = 1'b1; dmif.dm_rdata = 16'h7777;
    step();
    dmif.dm_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_cmp++; if (wb_valid !== 1'b0 || dmif.dm_re !== 1'b0) begin n_bad++; $display("FAIL t6_ghost cyc %0d got wbv=%b re=%b exp 0/0", k, wb_valid, dmif.dm_re); end
      step();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_pass_through();
    test_load_zero_wait();
    test_store_wait();
    test_timeout();
    test_reset();
    test_illegal();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
